// File: rtl/mem_pkg.sv
// Shared encodings for the load/store sequencer and the downstream load-data extender.
package mem_pkg;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, DONE, FLT} state_e;

    localparam logic CAUSE_MISALIGN = 1'b0;
    localparam logic CAUSE_TIMEOUT  = 1'b1;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane enable, store-data replication and alignment check for one access.
import mem_pkg::*;

module mem_lane_gen (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            // 2'b11 falls through here and behaves as a word access
            default: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus sequencer: accepts one access, runs a req/ack handshake with timeout,
// and hands the raw read word plus its byte enables to the load-data extender.
import mem_pkg::*;

module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic [31:0] ld_data,
    output logic [3:0]  ld_be,
    output logic        fault,
    output logic        fault_cause
);

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misaligned;

    mem_lane_gen u_lane_gen (
        .size       (size),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .misaligned (lane_misaligned)
    );

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [3:0]  ld_be_q, ld_be_d;
    logic        fault_q, fault_d;
    logic        fault_cause_q, fault_cause_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = 1'b0;
        ld_data_d     = ld_data_q;
        ld_be_d       = ld_be_q;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (lane_misaligned) begin
                        state_d       = FLT;
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = we;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = we ? lane_wdata : 32'h0;
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still completes normally
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!mem_we_q) begin
                        ld_data_d = mem_rdata;
                        ld_be_d   = mem_be_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = FLT;
                    mem_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            FLT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ready_q       <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_be_q      <= 4'h0;
            mem_wdata_q   <= 32'h0;
            done_q        <= 1'b0;
            ld_data_q     <= 32'h0;
            ld_be_q       <= 4'h0;
            fault_q       <= 1'b0;
            fault_cause_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            ld_data_q     <= ld_data_d;
            ld_be_q       <= ld_be_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign ready       = ready_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign done        = done_q;
    assign ld_data     = ld_data_q;
    assign ld_be       = ld_be_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;

endmodule
